rv32_instr_encoder: RTL and testbench
=====================================

Name: rv32_instr_encoder

Overview:
Streaming RV32I instruction encoder. It is the inverse of the immediate generator: it takes format, register, funct and immediate fields, packs the immediate into the bit positions each format uses, and emits a 32-bit instruction word. Each output word carries an instruction-memory byte address. Used by the test-program loader and self-checking benches to fill instruction memory through a valid/ready stream with a 2-entry output skid buffer.

Parameters:
ADDR_W, 32, width of out_addr.
BASE_ADDR, 0, byte address given to the first word after reset or clear.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
clear  in  1  synchronous; reloads address counter to BASE_ADDR; does not flush the buffer.
in_valid  in  1  input fields valid.
in_ready  out  1  encoder can accept a field set this cycle.
in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 invalid.
in_opcode  in  7  placed at [6:0].
in_rd  in  5  placed at [11:7] for R/I/U/J.
in_rs1  in  5  placed at [19:15] for R/I/S/B.
in_rs2  in  5  placed at [24:20] for R/S/B.
in_funct3  in  3  placed at [14:12] for R/I/S/B.
in_funct7  in  7  placed at [31:25] for R only.
in_imm  in  32  signed byte-offset/immediate value.
out_valid  out  1  output word valid.
out_ready  in  1  downstream accepts the word.
out_instr  out  32  encoded instruction.
out_addr  out  ADDR_W  byte address of out_instr.
out_err  out  1  immediate range or alignment violation, or invalid fmt.

Behaviour:
- Reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, skid entry empty, in_ready=1 on the cycle after reset deasserts.
- Reset mid-stream drops all buffered words. No output handshake completes in the reset cycle.
- Input handshake: in_valid & in_ready at edge N. Output handshake: out_valid & out_ready.
- Latency: a word accepted at edge N is visible at N+1 if the output register is empty or being drained. Otherwise it waits in the skid entry.
- Buffering: output register plus one skid entry. in_ready = ~skid_full, registered, with no combinational path from out_ready.
- Ordering: strict FIFO order; no loss and no duplication.
- Skid fill: on out_ready=0 with the output register full, an accepted word goes to skid.
- Skid drain: on the next output handshake, skid moves to the output register.
- Simultaneous drain and accept: both the output register and skid stay consistent.
- Address counter: holds the address to stamp on the next accepted word. It increments by 4 per input handshake and wraps modulo 2^ADDR_W.
- Address stamping: out_addr is the address stored with the word.
- Clear vs accept: if clear and an input handshake coincide, the accepted word gets BASE_ADDR and the counter becomes BASE_ADDR+4.
- Encoding, combinational before the buffer:
  - R: funct7|rs2|rs1|f3|rd|op; in_imm ignored; err=0.
  - I: imm[11:0]→[31:20]. err if imm ∉ [-2048, 2047]. Shift-immediate funct7 is supplied by the user in imm[11:5].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7]. err if imm ∉ [-2048, 2047].
  - B: imm[12]→[31], imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→[7]. err if imm ∉ [-4096, 4094] or imm[0]=1.
  - U: imm[31:12]→[31:12]. err if imm[11:0]≠0.
  - J: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12]. err if imm ∉ [-1048576, 1048574] or imm[0]=1.
  - fmt 6/7: out_instr=32'h00000013 (NOP), err=1.
- On range or alignment error the word is still emitted, built from the truncated bits, with err set. An error never stalls the stream.
- Fields not used by a format are forced to the immediate bits or zero as listed above; unused input fields never leak into the word.

Test Plan:
- I addi x1,x0,5 (fmt1, op 0x13, rd1, imm 5) after reset → out_instr=0x00500093, out_addr=0, err=0, out_valid one cycle after accept.
- B beq x1,x2,-8 → 0xFE208CE3. S sw x2,-4(x1) (f3=2, op 0x23) → 0xFE20AE23. Both err=0.
- J jal x1,2048 → 0x001000EF. U lui x5,0x12345000 → 0x123452B7. Then lui with imm 0x12345001 → err=1, instr 0x123452B7.
- Range checks: I with imm 2048 → err=1, instr[31:20]=0x800. B with imm 6 → err=0. B with imm 7 → err=1. fmt 6 → 0x00000013, err=1.
- Backpressure: stream 5 words with out_ready=0 for 3 cycles → in_ready falls after 2 accepts. Words then drain in order with addresses 0,4,8,12,16, no loss.
- Boundary events:
  - clear coincident with an accept → that word addr=BASE_ADDR.
  - ADDR_W=4 → addr wraps 12→0.
  - rst asserted with 2 words buffered → out_valid=0 next cycle, and the next word gets addr BASE_ADDR.

Source files
------------

// File: rtl/rv32_instr_encoder.sv
// rtl/rv32_instr_encoder.sv - RV32I field-to-instruction encoder with address stamping and skid-buffered output stream
module rv32_instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  logic signed [31:0] simm;
  logic [31:0]        enc_instr;
  logic               enc_err;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [ADDR_W-1:0]  word_addr;
  logic               skid_full;
  logic [31:0]        skid_instr;
  logic [ADDR_W-1:0]  skid_addr;
  logic               skid_err;
  logic               accept;
  logic               drain;

  assign simm      = in_imm;
  assign in_ready  = ~skid_full;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign word_addr = clear ? BASE_ADDR : addr_cnt;

  // Out-of-range immediates still produce a word from the truncated bits; only the flag changes.
  always_comb begin
    enc_instr = 32'h0000_0013;
    enc_err   = 1'b0;
    case (in_fmt)
      3'd0: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      3'd2: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      3'd3: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
      end
      3'd4: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = (in_imm[11:0] != 12'd0);
      end
      3'd5: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
      end
      default: begin
        enc_instr = 32'h0000_0013;
        enc_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt   <= BASE_ADDR;
      out_valid  <= 1'b0;
      out_instr  <= 32'd0;
      out_addr   <= BASE_ADDR;
      out_err    <= 1'b0;
      skid_full  <= 1'b0;
      skid_instr <= 32'd0;
      skid_addr  <= BASE_ADDR;
      skid_err   <= 1'b0;
    end else begin
      if (clear) begin
        addr_cnt <= accept ? BASE_ADDR + ADDR_STEP : BASE_ADDR;
      end else if (accept) begin
        addr_cnt <= addr_cnt + ADDR_STEP;
      end

      // Output register is free when empty or handing off this edge; skid always drains first.
      if (!out_valid || drain) begin
        if (skid_full) begin
          out_instr <= skid_instr;
          out_addr  <= skid_addr;
          out_err   <= skid_err;
          if (accept) begin
            skid_instr <= enc_instr;
            skid_addr  <= word_addr;
            skid_err   <= enc_err;
          end else begin
            skid_full <= 1'b0;
          end
        end else if (accept) begin
          out_valid <= 1'b1;
          out_instr <= enc_instr;
          out_addr  <= word_addr;
          out_err   <= enc_err;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_full  <= 1'b1;
        skid_instr <= enc_instr;
        skid_addr  <= word_addr;
        skid_err   <= enc_err;
      end
    end
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb/tb_rv32_instr_encoder.sv - scoreboard bench for rv32_instr_encoder
module tb_rv32_instr_encoder;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr, out_addr;
  logic        in_ready4, out_valid4, out_err4;
  logic [31:0] out_instr4;
  logic [3:0]  out_addr4;

  exp_t        q[$];
  exp_t        q4[$];
  logic [31:0] exp_addr;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  rv32_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'd0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err)
  );

  // Narrow-address twin sees the same accepted words and always drains; used for wrap checking.
  rv32_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd0)) u_dut4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid & in_ready), .in_ready(in_ready4),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid4), .out_ready(1'b1), .out_instr(out_instr4),
    .out_addr(out_addr4), .out_err(out_err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("instr", out_instr, e.instr);
          check("addr", out_addr, e.addr);
          check("err", {31'd0, out_err}, {31'd0, e.err});
        end
      end
      if (out_valid4) begin
        if (q4.size() == 0) begin
          check("spurious_out_valid4", {31'd0, out_valid4}, 32'd0);
        end else begin
          exp_t e;
          e = q4.pop_front();
          check("instr4", out_instr4, e.instr);
          check("addr4_wrap", {28'd0, out_addr4}, e.addr);
        end
      end
    end
  end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] ei, input logic ee, input logic clr);
    exp_t e;
    int   k;
    in_valid = 1'b1; in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; clear = clr;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("send_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      e.instr  = ei;
      e.err    = ee;
      e.addr   = clr ? 32'd0 : exp_addr;
      exp_addr = e.addr + 32'd4;
      q.push_back(e);
      e.addr   = e.addr & 32'hF;
      q4.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  function automatic logic [31:0] addi_word(input int rd, input int imm);
    return (32'(imm) << 20) + (32'(rd) << 7) + 32'h13;
  endfunction

  initial begin
    int k;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    exp_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8, 32'hFE208CE3, 1'b0, 1'b0);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, -32'sd4, 32'hFE20AE23, 1'b0, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 1'b0, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123452B7, 1'b1, 1'b0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1, 1'b0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h80000093, 1'b0, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h00000363, 1'b0, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h00000363, 1'b1, 1'b0);
    send(3'd6, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFFFFFF, 32'h00000013, 1'b1, 1'b0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFF, 32'h002081B3, 1'b0, 1'b0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 32'h402081B3, 1'b0, 1'b0);

    // clear coincident with accept restarts numbering at the base
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, addi_word(2, 9), 1'b0, 1'b1);
    send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10, addi_word(3, 10), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // backpressure: 5 words, output stalled for 3 cycles
    exp_addr  = 32'd0;
    clear     = 1'b1;
    @(posedge clk);
    #1 clear  = 1'b0;
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, addi_word(1, 3), 1'b0, 1'b0);
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, addi_word(2, 6), 1'b0, 1'b0);
    @(negedge clk);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      send(3'd1, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 3), addi_word(i, i * 3), 1'b0, 1'b0);
    end
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("bp_drained", q.size(), 32'd0);
    #1;

    // reset with two words buffered drops them
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, addi_word(7, 1), 1'b0, 1'b0);
    send(3'd1, 7'h13, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, addi_word(8, 2), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    q4.delete();
    exp_addr = 32'd0;
    @(negedge clk);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, addi_word(9, 4), 1'b0, 1'b0);

    k = 0;
    while ((q.size() != 0 || q4.size() != 0) && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("final_drained", q.size() + q4.size(), 32'd0);
    @(negedge clk);
    check("twin_in_ready", {31'd0, in_ready4}, 32'd1);
    check("final_out_err4_idle", {31'd0, out_valid4}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
